// File: rtl/br_resolve_q.sv
// br_resolve_q -- retire-side branch resolution queue.
//
// Predicted branches are allocated in program order at the tail, resolved
// out of order by execute, and retired in order from the head. Each retire
// drives the branch predictor update interface (rt_*). A mispredicted retire
// raises mispredict_flush with the recovery PC; on the edge that ends the
// flush cycle every entry is freed and the tail is pulled back to the head.
//
// Optional feature macro: BRQ_TARGET_CHECK_EN
//   defined   : a taken branch is correct only if its target equals the
//               fetch-time predicted PC (alloc_pred_pc is stored per entry).
//   undefined : correctness compares direction only; alloc_pred_pc unused.
//
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   alloc_* / alloc_tag          allocation request and granted entry (= tail)
//   full, count                  occupancy status
//   ex_valid/ex_tag/ex_taken/ex_target   resolution from execute
//   rt_*                         registered BP update strobe and attributes
//   mispredict_flush/_pc         registered flush pulse and recovery PC

`ifndef OBQ_SIZE
`define OBQ_SIZE 16
`endif

module br_resolve_q #(
  parameter int BRQ_SIZE  = 8,
  parameter int OBQ_IDX_W = $clog2(`OBQ_SIZE) + 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        alloc_en,
  input  logic [31:0]                 alloc_pc,
  input  logic                        alloc_cond,
  input  logic                        alloc_direct,
  input  logic                        alloc_pred_taken,
  input  logic [31:0]                 alloc_pred_pc,
  input  logic [OBQ_IDX_W-1:0]        alloc_obq_index,
  output logic [$clog2(BRQ_SIZE)-1:0] alloc_tag,
  output logic                        full,
  output logic [$clog2(BRQ_SIZE):0]   count,
  input  logic                        ex_valid,
  input  logic [$clog2(BRQ_SIZE)-1:0] ex_tag,
  input  logic                        ex_taken,
  input  logic [31:0]                 ex_target,
  output logic                        rt_en_branch,
  output logic                        rt_cond_branch,
  output logic                        rt_direct_branch,
  output logic                        rt_branch_taken,
  output logic                        rt_prediction_correct,
  output logic [31:0]                 rt_pc,
  output logic [31:0]                 rt_calculated_pc,
  output logic [OBQ_IDX_W-1:0]        rt_branch_index,
  output logic                        mispredict_flush,
  output logic [31:0]                 mispredict_pc
);

  localparam int TW = $clog2(BRQ_SIZE);
  localparam logic [TW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_DONE} entry_state_e;

  entry_state_e         state_q      [BRQ_SIZE];
  logic [31:0]          pc_q         [BRQ_SIZE];
  logic                 cond_q       [BRQ_SIZE];
  logic                 direct_q     [BRQ_SIZE];
  logic                 pred_taken_q [BRQ_SIZE];
  logic [OBQ_IDX_W-1:0] obq_q        [BRQ_SIZE];
  logic                 taken_q      [BRQ_SIZE];
  logic [31:0]          target_q     [BRQ_SIZE];
`ifdef BRQ_TARGET_CHECK_EN
  logic [31:0]          pred_pc_q    [BRQ_SIZE];
`else
  logic                 unused_pred_pc;
  assign unused_pred_pc = ^alloc_pred_pc;
`endif

  logic [TW:0]   head_q, tail_q;
  logic [TW-1:0] head_idx, tail_idx;
  logic          empty, do_retire, do_alloc, do_resolve, hd_correct;
  logic [31:0]   hd_calc_pc;

  assign head_idx  = head_q[TW-1:0];
  assign tail_idx  = tail_q[TW-1:0];
  assign empty     = (head_q == tail_q);
  assign full      = (head_idx == tail_idx) && (head_q[TW] != tail_q[TW]);
  assign count     = tail_q - head_q;
  assign alloc_tag = tail_idx;

  always_comb begin
    hd_calc_pc = taken_q[head_idx] ? target_q[head_idx] : pc_q[head_idx] + 32'd4;
    hd_correct = (taken_q[head_idx] == pred_taken_q[head_idx]);
`ifdef BRQ_TARGET_CHECK_EN
    if (taken_q[head_idx] && (target_q[head_idx] != pred_pc_q[head_idx]))
      hd_correct = 1'b0;
`endif
  end

  // While mispredict_flush is high the squash is pending on this edge, so
  // nothing retires and nothing allocates. An alloc alongside a mispredicted
  // retire is dropped since it would be squashed on the next edge anyway.
  assign do_retire  = !mispredict_flush && !empty && (state_q[head_idx] == ST_DONE);
  assign do_alloc   = alloc_en && !full && !mispredict_flush && !(do_retire && !hd_correct);
  // A slot being allocated this cycle is FREE, so a resolve to it never matches.
  assign do_resolve = ex_valid && (state_q[ex_tag] == ST_WAIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q                <= '0;
      tail_q                <= '0;
      for (int unsigned i = 0; i < BRQ_SIZE; i++) state_q[TW'(i)] <= ST_FREE;
      rt_en_branch          <= 1'b0;
      rt_cond_branch        <= 1'b0;
      rt_direct_branch      <= 1'b0;
      rt_branch_taken       <= 1'b0;
      rt_prediction_correct <= 1'b0;
      rt_pc                 <= '0;
      rt_calculated_pc      <= '0;
      rt_branch_index       <= '0;
      mispredict_flush      <= 1'b0;
      mispredict_pc         <= '0;
    end else begin
      rt_en_branch     <= 1'b0;
      mispredict_flush <= 1'b0;
      if (do_alloc) begin
        state_q[tail_idx] <= ST_WAIT;
        tail_q            <= tail_q + PTR_ONE;
      end
      if (do_resolve) state_q[ex_tag] <= ST_DONE;
      if (do_retire) begin
        state_q[head_idx]     <= ST_FREE;
        head_q                <= head_q + PTR_ONE;
        rt_en_branch          <= 1'b1;
        rt_cond_branch        <= cond_q[head_idx];
        rt_direct_branch      <= direct_q[head_idx];
        rt_branch_taken       <= taken_q[head_idx];
        rt_prediction_correct <= hd_correct;
        rt_pc                 <= pc_q[head_idx];
        rt_calculated_pc      <= hd_calc_pc;
        rt_branch_index       <= obq_q[head_idx];
        mispredict_flush      <= !hd_correct;
        mispredict_pc         <= hd_calc_pc;
      end
      if (mispredict_flush) begin
        for (int unsigned i = 0; i < BRQ_SIZE; i++) state_q[TW'(i)] <= ST_FREE;
        tail_q <= head_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_alloc) begin
      pc_q[tail_idx]         <= alloc_pc;
      cond_q[tail_idx]       <= alloc_cond;
      direct_q[tail_idx]     <= alloc_direct;
      pred_taken_q[tail_idx] <= alloc_pred_taken;
      obq_q[tail_idx]        <= alloc_obq_index;
`ifdef BRQ_TARGET_CHECK_EN
      pred_pc_q[tail_idx]    <= alloc_pred_pc;
`endif
    end
    if (do_resolve) begin
      taken_q[ex_tag]  <= ex_taken;
      target_q[ex_tag] <= ex_target;
    end
  end

endmodule

// File: doc/br_resolve_q.md
# br_resolve_q

Retire-side branch resolution queue that produces the branch predictor's update interface. Each predicted branch is allocated in program order with its fetch-time prediction and OBQ index. Execute resolves entries out of order, and the queue retires them in order. On retire it drives the BP `rt_*` inputs (taken, correct, calculated PC, OBQ index) and raises a misprediction flush with the recovery PC.

## Interface
Parameters:
- `BRQ_SIZE`, 8, number of entries (power of two, ≥2)
- `OBQ_IDX_W`, `$clog2(`OBQ_SIZE)+1`, width of the OBQ index carried per entry

Ports:
- `clock` in 1: single clock, all state updates on posedge
- `reset` in 1: synchronous, active-high
- `alloc_en` in 1: allocate entry for a predicted branch
- `alloc_pc` in 32: branch PC
- `alloc_cond` in 1: conditional branch
- `alloc_direct` in 1: direct branch
- `alloc_pred_taken` in 1: fetch-time direction prediction
- `alloc_pred_pc` in 32: fetch-time predicted next PC
- `alloc_obq_index` in `OBQ_IDX_W`: OBQ index from the BP
- `alloc_tag` out `$clog2(BRQ_SIZE)`: entry index granted this cycle (combinational = tail)
- `full` out 1: no free entry; `alloc_en` is ignored
- `count` out `$clog2(BRQ_SIZE)+1`: occupied entries
- `ex_valid` in 1: resolution from execute
- `ex_tag` in `$clog2(BRQ_SIZE)`: entry being resolved
- `ex_taken` in 1: actual direction
- `ex_target` in 32: computed target (taken path)
- `rt_en_branch`, `rt_cond_branch`, `rt_direct_branch`, `rt_branch_taken`, `rt_prediction_correct` out 1 each: BP update strobe and attributes
- `rt_pc`, `rt_calculated_pc` out 32
- `rt_branch_index` out `OBQ_IDX_W`
- `mispredict_flush` out 1: pulse; front end redirects and younger work is squashed
- `mispredict_pc` out 32: correct next PC on flush

## Operation
- Circular buffer with head and tail pointers. Each pointer carries an extra wrap bit. Empty when the pointers are equal including the wrap bit. Full when the indices are equal and the wrap bits differ.
- Each entry state is FREE, WAIT or DONE.
  - FREE→WAIT on alloc.
  - WAIT→DONE on `ex_valid` with a matching `ex_tag`. `taken` and `target` are latched at that point.
  - DONE→FREE on retire.
- `ex_valid` to a FREE or DONE entry is ignored: no state change, no error.
- Retire: when the head entry is DONE, at most one retire per cycle.
  - Calculated PC is `taken ? target : pc+4`. The 32-bit add wraps modulo 2^32.
  - A prediction is correct when the actual direction equals `pred_taken` and, if taken, `target == pred_pc` (see Configuration).
- Mispredict retire: `mispredict_flush` and `mispredict_pc` (the calculated PC) are set in the same cycle as `rt_en_branch`. On the following edge:
  - every entry becomes FREE;
  - tail = head;
  - `count` = 0.
- Alloc in the same cycle as a mispredict retire is dropped.
- Alloc and a correct retire in the same cycle are both performed, and `count` is unchanged. When `full`, alloc is refused even if a retire occurs that cycle.
- Resolve and alloc to the same slot in one cycle: the slot cannot be both FREE and WAIT, so the resolve is ignored.

## Timing
- Reset: all outputs are 0, except `alloc_tag` = 0 and `count` = 0. Pointers are 0 and all entries are FREE.
- Alloc in cycle N: the entry is WAIT from N+1. `alloc_tag` in cycle N names it.
- Resolve sampled at the end of cycle N: the entry is DONE in N+1.
- `rt_*` and flush outputs are registered. If the head is DONE in cycle M, the outputs are valid in M+1 for exactly one cycle. The minimum resolve→`rt_en_branch` latency is therefore 2 cycles.
- `rt_*` data holds its last value when `rt_en_branch` = 0. Only the strobes (`rt_en_branch`, `mispredict_flush`) are guaranteed 0.
- Reset asserted mid-operation overrides everything on that edge, and any pending flush is lost.

## Configuration
- `BRQ_TARGET_CHECK_EN` defined: a taken branch is correct only if the actual direction matches and `target == pred_pc`.
- `BRQ_TARGET_CHECK_EN` undefined: correctness compares direction only, and `alloc_pred_pc` is not stored. `mispredict_pc` is still the calculated PC.

## Test plan
- **Reset then single branch.** Alloc pc=0x100, pred_taken=1, pred_pc=0x200, obq=3. Resolve taken with target=0x200. Required: `rt_en_branch`=1 for one cycle 2 cycles after resolve, correct=1, `rt_calculated_pc`=0x200, `rt_branch_index`=3, no flush.
- **Direction mispredict.** Alloc pc=0x40, pred_taken=1. Resolve not-taken. Required: correct=0, flush=1, `mispredict_pc`=0x44, `count`=0 the next cycle.
- **Out-of-order resolve.** Alloc tags 0, 1, 2. Resolve in order 2, 1, 0. Required: nothing retires until tag 0 is DONE, then retires on three consecutive cycles in order 0, 1, 2.
- **Full.** Alloc 8 times. Required: `full`=1, `count`=8, and a 9th alloc is ignored. One retire plus alloc in the same cycle: the alloc is refused and `count`=7.
- **Flush squashes younger entries.** Entries 0–3 are WAIT. Entry 0 mispredicts while alloc_en=1 in the same cycle. Required: the alloc is dropped, all entries are FREE, and a later resolve of tag 2 is ignored.
- **Target mismatch with `BRQ_TARGET_CHECK_EN`.** pred_taken=1, pred_pc=0x300, resolve taken with target=0x340. Required: correct=0, `mispredict_pc`=0x340. Without the macro: correct=1.
